// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative integer square-root engine:
// FSM state encoding and width helpers used by the engine and its interface.
package sqrt_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sqrt_state_e;

    // $clog2 that never returns 0, so 1-entry selectors still get a bit
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

    // Padded radicand width: odd widths gain one zero MSB so digits pair up
    function automatic int wp_of(input int w);
        return w + (w % 2);
    endfunction

endpackage

// File: rtl/sqrt_iter_engine_if.sv
// Start/done handshake and result bus between input capture and the
// display decoders. Root/remainder widths follow the radicand width W.
interface sqrt_iter_engine_if #(
    parameter int W = 8
);
    import sqrt_pkg::*;

    localparam int N = wp_of(W) / 2;

    logic         start;
    logic [W-1:0] din;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] root;
    logic [N:0]   rem;
    logic         perfect;

    modport master (
        output start, din,
        input  ready, busy, done, root, rem, perfect
    );

    modport slave (
        input  start, din,
        output ready, busy, done, root, rem, perfect
    );

endinterface

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration: bring down the next
// two radicand bits, trial-subtract (4r+1), and append the resulting root bit.
module sqrt_step #(
    parameter int N = 4
) (
    input  logic [N+1:0] p,
    input  logic [N-1:0] r,
    input  logic [1:0]   x2,
    output logic [N+1:0] p_next,
    output logic [N-1:0] r_next
);

    logic [N+3:0] pp;
    logic [N+1:0] t;
    logic [N+1:0] diff;
    logic         ge;

    // Trial subtraction; the compare uses the full shifted value so no bit
    // of the partial remainder is silently discarded.
    always_comb begin
        pp     = {p, x2};
        t      = {r, 2'b01};
        ge     = (pp >= {2'b00, t});
        diff   = pp[N+1:0] - t;
        p_next = ge ? diff : pp[N+1:0];
        r_next = N'({r, ge});
    end

endmodule

// File: rtl/sqrt_iter_engine.sv
// Sequential integer square root, one root bit per clock (restoring method).
// Optional per-step partial-root trace: define SQRT_ENGINE_TRACE_EN.
module sqrt_iter_engine
    import sqrt_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    sqrt_iter_engine_if.slave                 bus
`ifdef SQRT_ENGINE_TRACE_EN
    ,
    input  logic [clog2_min1(wp_of(W)/2)-1:0] trace_sel,
    output logic [wp_of(W)/2-1:0]             trace_root
`endif
);

    localparam int WP = wp_of(W);
    localparam int N  = WP / 2;
    localparam int CW = clog2_min1(N);

    sqrt_state_e  state_q, state_d;
    logic [WP-1:0] x_q;
    logic [N-1:0]  r_q;
    logic [N+1:0]  p_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  root_q;
    logic [N:0]    rem_q;
    logic          perfect_q;
    logic          done_q;
    logic          last_step;

    logic [N+1:0]  p_next;
    logic [N-1:0]  r_next;

    sqrt_step #(.N(N)) u_step (
        .p      (p_q),
        .r      (r_q),
        .x2     (x_q[WP-1 -: 2]),
        .p_next (p_next),
        .r_next (r_next)
    );

    assign last_step = (cnt_q == CW'(N-1));

    // Next-state logic: idle until start, N steps, one result cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath: capture on accept, iterate in RUN, publish results in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            r_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            root_q    <= '0;
            rem_q     <= '0;
            perfect_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (bus.start) begin
                    x_q   <= WP'(bus.din);
                    r_q   <= '0;
                    p_q   <= '0;
                    cnt_q <= '0;
                end
                S_RUN: begin
                    x_q   <= x_q << 2;
                    r_q   <= r_next;
                    p_q   <= p_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_DONE: begin
                    root_q    <= r_q;
                    rem_q     <= p_q[N:0];
                    perfect_q <= (p_q == '0);
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SQRT_ENGINE_TRACE_EN
    logic [N-1:0][N-1:0] trace_q;

    // Partial root after each step, cleared whenever a new operation starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            trace_q <= '0;
        end else if (state_q == S_RUN) begin
            trace_q[cnt_q] <= r_next;
        end
    end

    // Combinational read; selectors past the last step read zero
    always_comb begin
        trace_root = '0;
        if (int'(trace_sel) < N) trace_root = trace_q[trace_sel];
    end
`endif

    assign bus.ready   = (state_q == S_IDLE);
    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = done_q;
    assign bus.root    = root_q;
    assign bus.rem     = rem_q;
    assign bus.perfect = perfect_q;

endmodule

// File: tb/tb_sqrt_iter_engine.sv
// Scoreboard bench for sqrt_iter_engine: directed radicands with hand-computed
// roots; a monitor pops expected results on every done pulse.
module tb_sqrt_iter_engine;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    int   pushes;
    int   dones;

    typedef struct {
        int root;
        int rem;
        int perf;
        int c0;
    } exp_t;

    exp_t q[$];

    sqrt_iter_engine_if #(.W(8))  bus8 ();
    sqrt_iter_engine_if #(.W(16)) bus16 ();
    sqrt_iter_engine_if #(.W(7))  bus7 ();

`ifdef SQRT_ENGINE_TRACE_EN
    logic [1:0] tsel8;
    logic [3:0] tr8;
    logic [2:0] tsel16;
    logic [7:0] tr16;
    logic [1:0] tsel7;
    logic [3:0] tr7;
`endif

    sqrt_iter_engine #(.W(8)) dut8 (
        .clk (clk), .rst_n (rst_n), .bus (bus8)
`ifdef SQRT_ENGINE_TRACE_EN
        , .trace_sel (tsel8), .trace_root (tr8)
`endif
    );

    sqrt_iter_engine #(.W(16)) dut16 (
        .clk (clk), .rst_n (rst_n), .bus (bus16)
`ifdef SQRT_ENGINE_TRACE_EN
        , .trace_sel (tsel16), .trace_root (tr16)
`endif
    );

    sqrt_iter_engine #(.W(7)) dut7 (
        .clk (clk), .rst_n (rst_n), .bus (bus7)
`ifdef SQRT_ENGINE_TRACE_EN
        , .trace_sel (tsel7), .trace_root (tr7)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse from the W=8 engine must match the oldest request
    always @(negedge clk) begin
        if (rst_n && bus8.done) begin
            exp_t e;
            dones++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("root",    bus8.root,    e.root);
                chk("rem",     bus8.rem,     e.rem);
                chk("perfect", bus8.perfect, e.perf);
                chk("latency", cyc - e.c0,   6);
            end
        end
    end

    // Wait for ready, present a radicand, and record what should come back
    task automatic issue8(input int d, input int er, input int erm, input int ep, input bit hold);
        int g = 0;
        while (!bus8.ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!bus8.ready) begin
            chk("issue_timeout", 0, 1);
            return;
        end
        bus8.din   = 8'(d);
        bus8.start = 1'b1;
        q.push_back('{er, erm, ep, cyc});
        pushes++;
        @(negedge clk);
        if (!hold) bus8.start = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},   bus8.ready,   1);
        chk({tag, "_busy"},    bus8.busy,    0);
        chk({tag, "_done"},    bus8.done,    0);
        chk({tag, "_root"},    bus8.root,    0);
        chk({tag, "_rem"},     bus8.rem,     0);
        chk({tag, "_perfect"}, bus8.perfect, 1);
    endtask

    initial begin
        int g;
        int c0;
        int exp_tr[4];
        exp_tr = '{1, 2, 5, 11};
        errors = 0; checks = 0; pushes = 0; dones = 0; cyc = 0;
        rst_n = 1'b0;
        bus8.start  = 1'b0; bus8.din  = '0;
        bus16.start = 1'b0; bus16.din = '0;
        bus7.start  = 1'b0; bus7.din  = '0;
`ifdef SQRT_ENGINE_TRACE_EN
        tsel8 = '0; tsel16 = '0; tsel7 = '0;
`endif
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // 127 -> 11 r6
        issue8(127, 11, 6, 0, 1'b0);
        drain();
`ifdef SQRT_ENGINE_TRACE_EN
        for (int i = 0; i < 4; i++) begin
            tsel8 = 2'(i);
            #1;
            chk("trace_root", tr8, exp_tr[i]);
        end
`endif

        // Back-to-back with start held: 144 then 0
        issue8(144, 12, 0, 1, 1'b1);
        issue8(0, 0, 0, 1, 1'b0);
        drain();

        // Full-scale 8-bit
        issue8(255, 15, 30, 0, 1'b0);
        drain();

        // Start pulsed mid-run with another radicand must be ignored
        issue8(200, 14, 4, 0, 1'b0);
        @(negedge clk);
        chk("busy_midrun", bus8.busy, 1);
        bus8.din   = 8'd9;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.din   = '0;
        drain();

        // W=16 full scale: no overflow of the partial remainder
        bus16.din   = 16'hFFFF;
        bus16.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        bus16.start = 1'b0;
        g = 0;
        while (!bus16.done && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("w16_done_seen", bus16.done, 1);
        chk("w16_root",      bus16.root, 255);
        chk("w16_rem",       bus16.rem,  510);
        chk("w16_perfect",   bus16.perfect, 0);
        chk("w16_latency",   cyc - c0, 10);
        @(negedge clk);

        // W=7 (odd, padded to 8)
        bus7.din   = 7'd127;
        bus7.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        bus7.start = 1'b0;
        g = 0;
        while (!bus7.done && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("w7_done_seen", bus7.done, 1);
        chk("w7_root",      bus7.root, 11);
        chk("w7_rem",       bus7.rem,  6);
        chk("w7_latency",   cyc - c0,  6);
        @(negedge clk);

        // Abort: reset during RUN step 2; no done may follow
        bus8.din   = 8'd127;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", bus8.busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", dones, pushes);

        // Fresh operation after abort: 46 -> 6 r10
        issue8(46, 6, 10, 0, 1'b0);
        drain();

        chk("queue_empty", q.size(), 0);
        chk("done_count",  dones, pushes);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/sqrt_iter_engine.md
Name: sqrt_iter_engine

Overview:
- Parametrised sequential integer square-root engine. It is the clocked successor to the combinational 7-bit switch-driven square-root finder.
- Computes floor(sqrt(din)) and the remainder for any input width, one root bit per clock, using the restoring digit-by-digit method.
- Sits between the switch/input capture logic and the HEX/LED display decoders of the top level, with a start/done handshake.

Parameters:
- W, 8, radicand width in bits (>=2). An odd W is zero-extended internally to WP = W+1. Otherwise WP = W.
- N, WP/2 (derived localparam, not overridable), number of iterations and root width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request. Sampled only when ready=1.
- din  in  W  radicand. Captured on the accepted start edge.
- ready  out  1  high in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- root  out  N  floor(sqrt(din)). Held until the next completion.
- rem  out  N+1  din - root*root. Held until the next completion.
- perfect  out  1  rem==0. Held with root.
- trace_sel  in  clog2(N) (min 1)  step index. Present only with the optional feature.
- trace_root  out  N  partial root after step trace_sel. Present only with the optional feature.

Behaviour:
- Reset (async assert, sync release): state=IDLE; ready=1; busy=0; done=0; root=0; rem=0; perfect=1; all internal registers 0; trace buffer 0.
- IDLE:
  - start=1 latches din (zero-extended to WP) into shift register x.
  - Clears the partial root r and partial remainder p (N+2 bits).
  - Loads step counter cnt=0 and moves to RUN.
- RUN, one step per cycle:
  - p' = (p<<2) | x[WP-1:WP-2]; x <<= 2; t = (r<<2)|1.
  - If p' >= t: p = p'-t and r = (r<<1)|1. Otherwise p = p' and r = r<<1.
  - cnt increments. After step N-1, move to DONE.
- DONE (exactly one cycle):
  - root=r; rem=p[N:0]; perfect=(p==0); done=1.
  - Moves to IDLE next cycle.
- Latency: start accepted at edge k; done is high in the cycle following edge k+N+1. Throughput is one result per N+2 cycles.
- start while busy or in DONE is ignored. There is no queueing. din changes during RUN have no effect.
- rem never exceeds 2*root, so N+1 bits is sufficient. The internal p keeps N+2 bits to hold p' before subtraction.
- rst_n asserted mid-RUN aborts the operation. Outputs return to their reset values, and no done pulse is issued.
- din=0 yields root=0, rem=0, perfect=1. din=2^W-1 must not overflow p.

Optional Feature:
- Macro SQRT_ENGINE_TRACE_EN.
- Defined:
  - An N-entry x N-bit trace buffer records r after every RUN step (entry cnt).
  - trace_root = buffer[trace_sel] is a combinational read. An out-of-range sel reads 0.
  - The buffer is cleared on accepted start and on reset.
  - This supports step-by-step display of the algorithm on HEX via switch-selected step.
- Undefined: trace_sel/trace_root ports and the buffer are absent. Core behaviour and timing are identical.

Decomposition:
- Shared package sqrt_pkg holds:
  - state enum {S_IDLE, S_RUN, S_DONE};
  - function clog2_min1;
  - localparam helper for WP/N derivation.
- One natural sub-module, sqrt_step: the combinational single iteration (inputs p, r, top two bits; outputs p_next, r_next). It is reusable by a future unrolled or pipelined variant.
- The FSM, counter, and registers stay in sqrt_iter_engine.

Test Plan:
- W=8, din=127, start pulse -> done after N+2=6 cycles; root=11, rem=6, perfect=0. With trace enabled, trace_sel 0..3 reads 1,2,5,11.
- W=8, din=144 then din=0 back-to-back (start held high) -> results 12/0/perfect=1, then 0/0/perfect=1. The second start is accepted only when ready returns.
- W=8, din=255 -> root=15, rem=30. With W=16, din=65535 -> root=255, rem=510 (no overflow).
- W=7 (odd), din=127 -> root=11, rem=6. Latency is N+2 = 6 cycles (WP=8).
- Pulse start during RUN with a different din -> ignored; first result unchanged; exactly one done pulse.
- Assert rst_n low at RUN step 2 of din=127 -> immediate reset values; no done. After release, a new start with din=46 gives root=6, rem=10.
